// File: rtl/lock_access_controller_if.sv
// Keypad/lock-core signal bundle for lock_access_controller.
// master: keypad and lock-core side; slave: the controller.
interface lock_access_controller_if;
  logic [3:0] key_raw;
  logic       core_wrong;
  logic       core_unlocked;
  logic [3:0] key_code;
  logic       key_valid;
  logic       lockout;
  logic [2:0] fail_count;

  modport master (
    output key_raw, core_wrong, core_unlocked,
    input  key_code, key_valid, lockout, fail_count
  );

  modport slave (
    input  key_raw, core_wrong, core_unlocked,
    output key_code, key_valid, lockout, fail_count
  );
endinterface

// File: rtl/lock_access_controller.sv
// Keypad front end for a lock core: synchronises and debounces the raw
// keypad code, forwards each accepted key as a one-cycle pulse, counts
// failed attempts and blocks the keypad for a fixed time after too many.
module lock_access_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_FAILS       = 3,
  parameter int LOCKOUT_CYCLES  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  lock_access_controller_if.slave  bus
);

  localparam logic [3:0] DB_C        = 4'(DEBOUNCE_CYCLES);
  localparam logic [2:0] MAX_C       = 3'(MAX_FAILS);
  localparam logic [7:0] LO_C        = 8'(LOCKOUT_CYCLES);
  localparam logic [3:0] CODE_NONE   = 4'b1111;
  localparam logic [3:0] CODE_CANCEL = 4'b1101;

  typedef enum logic [1:0] {READY, CANCEL, LOCKOUT} state_t;

  state_t     state, state_d;
  logic [3:0] sync1, sync2;
  logic [3:0] stable_cnt;
  logic [3:0] last_acc;
  logic       wrong_q, unl_q;
  logic       wrong_rise, unl_rise, accept;
  logic [2:0] fail_q, fail_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] code_q, code_d;
  logic       valid_q;

  // Two-flop synchroniser, stability counter and last-accepted-code tracking.
  // The counter clears on the edge where sync2 is about to change, so it
  // measures how long the current sync2 value has been stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= '1;
      sync2      <= '1;
      stable_cnt <= '0;
      last_acc   <= '1;
    end else begin
      sync1 <= bus.key_raw;
      sync2 <= sync1;
      if (sync1 != sync2)
        stable_cnt <= '0;
      else if (stable_cnt < DB_C)
        stable_cnt <= stable_cnt + 4'd1;
      if (accept)
        last_acc <= sync2;
    end
  end

  assign accept = (stable_cnt == DB_C) && (sync2 != last_acc);

  // Registered rising-edge detection of the lock-core status levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrong_q <= 1'b0;
      unl_q   <= 1'b0;
    end else begin
      wrong_q <= bus.core_wrong;
      unl_q   <= bus.core_unlocked;
    end
  end

  assign wrong_rise = bus.core_wrong & ~wrong_q;
  assign unl_rise   = bus.core_unlocked & ~unl_q;

  // State, fail counter, lockout timer and registered key output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= READY;
      fail_q  <= '0;
      timer_q <= '0;
      code_q  <= '1;
      valid_q <= 1'b0;
    end else begin
      state   <= state_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
      code_q  <= code_d;
      valid_q <= (code_d != CODE_NONE);
    end
  end

  // Next-state logic. The cancel code is produced on the transition edge so
  // that it coincides with the first cycle of CANCEL/LOCKOUT; the timer
  // counts LOCKOUT_CYCLES..1 so lockout lasts exactly LOCKOUT_CYCLES clocks.
  always_comb begin
    state_d = state;
    fail_d  = fail_q;
    timer_d = timer_q;
    code_d  = CODE_NONE;
    case (state)
      READY: begin
        if (wrong_rise) begin
          code_d = CODE_CANCEL;
          fail_d = fail_q + 3'd1;
          if ((fail_q + 3'd1) == MAX_C) begin
            state_d = LOCKOUT;
            timer_d = LO_C;
          end else begin
            state_d = CANCEL;
          end
        end else begin
          if (unl_rise)
            fail_d = '0;
          if (accept && (sync2 != CODE_NONE))
            code_d = sync2;
        end
      end
      CANCEL: begin
        state_d = READY;
      end
      LOCKOUT: begin
        timer_d = timer_q - 8'd1;
        if (timer_q <= 8'd1) begin
          state_d = READY;
          fail_d  = '0;
          timer_d = '0;
        end
      end
      default: begin
        state_d = READY;
      end
    endcase
  end

  assign bus.key_code   = code_q;
  assign bus.key_valid  = valid_q;
  assign bus.lockout    = (state == LOCKOUT);
  assign bus.fail_count = fail_q;

endmodule

// File: doc/lock_access_controller.md
LOCK_ACCESS_CONTROLLER -- requirements
Module: lock_access_controller

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the consecutive stable cycles needed to accept a key (legal 1..15).
REQ-002 The block SHALL have parameter MAX_FAILS, default 3, giving the failed attempts that trigger lockout (legal 1..7).
REQ-003 The block SHALL have parameter LOCKOUT_CYCLES, default 16, giving the lockout duration in clocks (legal 1..255).

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have port clk, input, 1, the single clock; all flops use its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-006 The block SHALL have port key_raw, input, 4, the unsynchronised keypad code (1111 none, 1110 set_passcode, 1101 cancel, 0001-1001 digits).
REQ-007 The block SHALL have port core_wrong, input, 1, the lock-core "wrong" state level.
REQ-008 The block SHALL have port core_unlocked, input, 1, the lock-core unlock level.
REQ-009 The block SHALL have port key_code, output, 4, the code presented to the lock core; 1111 when idle.
REQ-010 The block SHALL have port key_valid, output, 1, which is high exactly in cycles where key_code is not 1111.
REQ-011 The block SHALL have port lockout, output, 1, which is high while keypad input is blocked.
REQ-012 The block SHALL have port fail_count, output, 3, the current count of failed attempts.

Function
REQ-013 The block SHALL pass key_raw through a 2-flop synchroniser before any other use.
REQ-014 Debounce: a stable counter SHALL reset whenever the synchronised code changes and increment otherwise, saturating at DEBOUNCE_CYCLES.
REQ-015 A synchronised code SHALL be accepted in the cycle the stable counter reaches DEBOUNCE_CYCLES, and only if it differs from the last accepted code.
REQ-016 When the accepted code is not 1111, the block SHALL drive one forward pulse: key_code = code and key_valid = 1 for exactly 1 cycle, registered.
REQ-017 Latency: with key_raw held from edge E, the forward pulse SHALL be visible on outputs after edge E+DEBOUNCE_CYCLES+2.
REQ-018 Holding a key SHALL produce no repeated pulse; accepting 1111 re-arms the block so the same key can be accepted again.
REQ-019 The controller FSM SHALL have exactly three states: READY, CANCEL and LOCKOUT.
REQ-020 READY: the block SHALL forward accepted keys.
REQ-021 READY: a rising edge of core_wrong (registered edge detect) SHALL increment fail_count.
REQ-022 READY: if the incremented fail_count equals MAX_FAILS, the FSM SHALL go to LOCKOUT; otherwise it SHALL go to CANCEL.
REQ-023 CANCEL: the block SHALL drive key_code = 1101, key_valid = 1 for 1 cycle, then return to READY.
REQ-024 LOCKOUT entry: the block SHALL drive 1101 with key_valid = 1 for the first cycle, hold lockout = 1, and load the timer with LOCKOUT_CYCLES.
REQ-025 LOCKOUT: the timer SHALL decrement each cycle; all accepted keys SHALL be discarded, not queued.
REQ-026 LOCKOUT exit: at timer = 0, the block SHALL clear fail_count, deassert lockout and go to READY on the next cycle; lockout is high for exactly LOCKOUT_CYCLES cycles.
REQ-027 A rising edge of core_unlocked SHALL clear fail_count to 0 in READY.
REQ-028 Simultaneous events: a core_wrong edge and a key acceptance in the same cycle SHALL give the cancel priority; the key is dropped.
REQ-029 Simultaneous events: a core_unlocked edge together with a core_wrong edge SHALL be treated as a failure.
REQ-030 A user-entered 1101 SHALL be forwarded like any key in READY and SHALL NOT affect fail_count.
REQ-031 fail_count SHALL never exceed MAX_FAILS; core_wrong edges during CANCEL or LOCKOUT SHALL be ignored.

Reset
REQ-032 While rst_n = 0, the block SHALL hold key_code = 1111, key_valid = 0, lockout = 0, fail_count = 0 and FSM = READY.
REQ-033 While rst_n = 0, the synchroniser SHALL be 1111, the stable counter and timer SHALL be 0, the last accepted code SHALL be 1111, and the edge-detect flops SHALL be 0.
REQ-034 Reset asserted mid-LOCKOUT or mid-pulse SHALL abort immediately, asynchronously, with no further pulse after release.
REQ-035 After rst_n deasserts, the first forward pulse SHALL require a full debounce period.

Verification
REQ-036 Hold key_raw = 0011 for 10 cycles -> exactly one pulse key_code = 0011 at edge E+6; key_valid high 1 cycle; otherwise key_code = 1111.
REQ-037 key_raw toggles 0101/1111 every 2 cycles (bounce) -> no pulse; then hold 0101 for 6 cycles -> one pulse.
REQ-038 Hold 0111, release to 1111 for 6 cycles, hold 0111 again -> two separate pulses of 0111.
REQ-039 Pulse core_wrong 3 times (gaps of 5 cycles) -> fail_count 1, 2, then lockout = 1 for exactly 16 cycles; 1101 pulse after each failure; keys pressed during lockout produce no pulse; fail_count = 0 after lockout.
REQ-040 fail_count = 2, then core_unlocked rises -> fail_count = 0; next core_wrong gives fail_count = 1 with no lockout.
REQ-041 Assert rst_n = 0 for 1 cycle in the middle of lockout -> all outputs are at reset values immediately; after release, a held key pulses only after a full debounce period.
